// File: rtl/mem_ctrl_if.sv
// Cache-side request/response and byte-bus signals of the memory controller.
// The controller connects through the slave modport, requesters and the RAM through master.
interface mem_ctrl_if;
    logic        ic_req_en;
    logic [31:0] ic_req_add;
    logic        ic_abort;
    logic        ic_done;
    logic [31:0] ic_dat;

    logic        dc_req_en;
    logic        dc_req_rw;
    logic [1:0]  dc_req_len;
    logic [31:0] dc_req_add;
    logic [31:0] dc_req_dat;
    logic        dc_done;
    logic [31:0] dc_dat;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport master (
        output ic_req_en, ic_req_add, ic_abort,
        input  ic_done, ic_dat,
        output dc_req_en, dc_req_rw, dc_req_len, dc_req_add, dc_req_dat,
        input  dc_done, dc_dat,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  ic_req_en, ic_req_add, ic_abort,
        output ic_done, ic_dat,
        input  dc_req_en, dc_req_rw, dc_req_len, dc_req_add, dc_req_dat,
        output dc_done, dc_dat,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IC/DC requests (DC first) and serialises
// each 1/2/4-byte transaction onto the 8-bit RAM/IO bus, assembling little-endian reads.
module mem_ctrl (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    logic        is_ic;
    logic [1:0]  len;
    logic [31:0] add;
    logic [31:0] dat;
    logic [31:0] asm_r;
    logic [2:0]  cnt;
    logic        mem_wr_r;

    logic [1:0]  cap_idx;
    logic [31:0] asm_next;
    logic        last_cap;
    logic        io_stall;
    logic [31:0] next_a;
    logic [7:0]  next_byte;

    // In RD, cnt is the offset currently on mem_a; byte cnt-1 arrives on mem_din.
    always_comb begin
        cap_idx  = 2'(cnt - 3'd1);
        asm_next = asm_r;
        asm_next[{cap_idx, 3'b000} +: 8] = bus.mem_din;
        last_cap  = (cnt != 3'd0) && (cap_idx == len);
        io_stall  = (add[17:16] == 2'b11) && bus.io_buffer_full;
        next_a    = add + 32'(cnt) + 32'd1;
        next_byte = 8'(dat >> {cnt[1:0] + 2'd1, 3'b000});
    end

    assign bus.mem_wr = mem_wr_r & rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            is_ic        <= 1'b0;
            len          <= '0;
            add          <= '0;
            dat          <= '0;
            asm_r        <= '0;
            cnt          <= '0;
            mem_wr_r     <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_dout <= '0;
            bus.ic_done  <= 1'b0;
            bus.dc_done  <= 1'b0;
            bus.ic_dat   <= '0;
            bus.dc_dat   <= '0;
        end else if (rdy_in) begin
            bus.ic_done <= 1'b0;
            bus.dc_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    asm_r <= '0;
                    if (bus.dc_req_en) begin
                        is_ic        <= 1'b0;
                        len          <= bus.dc_req_len;
                        add          <= bus.dc_req_add;
                        dat          <= bus.dc_req_dat;
                        bus.mem_a    <= bus.dc_req_add;
                        bus.mem_dout <= bus.dc_req_dat[7:0];
                        mem_wr_r     <= bus.dc_req_rw &&
                                        !((bus.dc_req_add[17:16] == 2'b11) && bus.io_buffer_full);
                        state        <= bus.dc_req_rw ? WR : RD;
                    end else if (bus.ic_req_en && !bus.ic_abort) begin
                        is_ic     <= 1'b1;
                        len       <= 2'd3;
                        add       <= bus.ic_req_add;
                        bus.mem_a <= bus.ic_req_add;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (is_ic && bus.ic_abort) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0)
                            asm_r <= asm_next;
                        if (cnt < {1'b0, len})
                            bus.mem_a <= next_a;
                        if (last_cap) begin
                            if (is_ic) begin
                                bus.ic_done <= 1'b1;
                                bus.ic_dat  <= asm_next;
                            end else begin
                                bus.dc_done <= 1'b1;
                                bus.dc_dat  <= asm_next;
                            end
                            state <= DONE;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                WR: begin
                    // mem_wr_r low means the byte on the bus is still pending behind an IO stall.
                    if (mem_wr_r) begin
                        if (cnt[1:0] == len) begin
                            mem_wr_r    <= 1'b0;
                            bus.dc_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt          <= cnt + 3'd1;
                            bus.mem_a    <= next_a;
                            bus.mem_dout <= next_byte;
                            mem_wr_r     <= !io_stall;
                        end
                    end else begin
                        mem_wr_r <= !io_stall;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed timing cases plus randomized traffic
// checked against a byte-array model of RAM and per-source expected-response queues.
`timescale 1ns/1ps
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in;
    logic rdy_dir = 1'b1, rdy_rnd = 1'b1;
    logic io_dir = 1'b0, io_rnd = 1'b0;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    assign rdy_in = rdy_dir & rdy_rnd;
    assign bus.io_buffer_full = io_dir | io_rnd;

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic [32:0] exp_dc[$];
    logic [31:0] exp_ic[$];
    logic [39:0] exp_wr[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int ic_cnt = 0, dc_cnt = 0, ic_cyc = 0, dc_cyc = 0, wr_cnt = 0;
    int t_ic = 0, t_dc = 0;
    bit rand_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM device: shares the global enable, read data valid the cycle after its address.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rdy_in) bus.mem_din <= ram[bus.mem_a[17:0]];
        if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
    end

    initial forever begin
        @(posedge clk_in);
        #1;
        rdy_rnd = rand_en ? ($urandom_range(7) != 0) : 1'b1;
        io_rnd  = rand_en ? ($urandom_range(3) == 0) : 1'b0;
    end

    always @(negedge clk_in) begin
        if (rst_in && rdy_in) begin
            if (bus.ic_done) begin
                ic_cnt++;
                ic_cyc = cyc;
                if (exp_ic.size() == 0) chk("ic_done_unexpected", 1, 0);
                else chk("ic_dat", bus.ic_dat, exp_ic.pop_front());
            end
            if (bus.dc_done) begin
                dc_cnt++;
                dc_cyc = cyc;
                if (exp_dc.size() == 0) chk("dc_done_unexpected", 1, 0);
                else begin
                    logic [32:0] e;
                    e = exp_dc.pop_front();
                    if (e[32]) chk("dc_wr_bytes_left", exp_wr.size(), 0);
                    else chk("dc_dat", bus.dc_dat, e[31:0]);
                end
            end
            if (bus.mem_wr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) chk("wr_unexpected", {bus.mem_a, bus.mem_dout}, 0);
                else chk("wr_strobe", {bus.mem_a, bus.mem_dout}, exp_wr.pop_front());
            end
        end
    end

    task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
        ram[a[17:0]] <= v;
        ref_mem[a[17:0]] = v;
    endtask

    task automatic issue_ic(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] ak;
        for (int k = 0; k < 4; k++) begin
            ak = a + 32'(k);
            w[8*k +: 8] = ref_mem[ak[17:0]];
        end
        exp_ic.push_back(w);
        bus.ic_req_add = a;
        bus.ic_req_en  = 1'b1;
        t_ic = cyc;
    endtask

    task automatic issue_dc(input logic rw, input logic [1:0] len, input logic [31:0] a,
                            input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] ak;
        w = '0;
        for (int k = 0; k <= int'(len); k++) begin
            ak = a + 32'(k);
            if (rw) begin
                ref_mem[ak[17:0]] = d[8*k +: 8];
                exp_wr.push_back({ak, d[8*k +: 8]});
            end else begin
                w[8*k +: 8] = ref_mem[ak[17:0]];
            end
        end
        exp_dc.push_back({rw, w});
        bus.dc_req_rw  = rw;
        bus.dc_req_len = len;
        bus.dc_req_add = a;
        bus.dc_req_dat = d;
        bus.dc_req_en  = 1'b1;
        t_dc = cyc;
    endtask

    task automatic wait_done(input bit is_ic, input int budget, output int lat);
        int c0;
        int n;
        c0 = is_ic ? ic_cnt : dc_cnt;
        n = 0;
        lat = -1;
        while (n < budget) begin
            @(posedge clk_in);
            n++;
            if ((is_ic ? ic_cnt : dc_cnt) != c0) begin
                lat = is_ic ? ic_cyc - t_ic : dc_cyc - t_dc;
                break;
            end
        end
        if (lat < 0) begin
            if (is_ic) chk("ic_timeout", 1, 0);
            else chk("dc_timeout", 1, 0);
        end
        #1;
        if (is_ic) bus.ic_req_en = 1'b0;
        else bus.dc_req_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w0;
        int mism;
        logic [7:0] b;
        logic [31:0] a;
        logic [1:0] len;

        bus.ic_req_en = 0; bus.ic_req_add = '0; bus.ic_abort = 0;
        bus.dc_req_en = 0; bus.dc_req_rw = 0; bus.dc_req_len = '0;
        bus.dc_req_add = '0; bus.dc_req_dat = '0;
        for (int i = 0; i < 262144; i++) begin
            b = 8'($urandom);
            ram[i] <= b;
            ref_mem[i] = b;
        end

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_outputs", {bus.ic_done, bus.dc_done, bus.mem_wr, bus.mem_a, bus.mem_dout,
                              bus.ic_dat, bus.dc_dat}, 0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // IC fetch of 13 05 00 00 from 0x100
        set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h05);
        set_byte(32'h102, 8'h00); set_byte(32'h103, 8'h00);
        issue_ic(32'h100);
        @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("ic_addr_seq", bus.mem_a, 32'h100 + 32'(k));
        end
        wait_done(1, 30, lat);
        chk("ic_latency", lat, 6);
        chk("ic_dat_0513", bus.ic_dat, 32'h0000_0513);

        // Same-cycle IC and DC: DC wins
        issue_dc(1'b1, 2'd0, 32'h1000, 32'hAB);
        issue_ic(32'h200);
        wait_done(0, 30, lat);
        chk("dc_first_latency", lat, 2);
        wait_done(1, 30, lat);
        chk("ic_after_dc_latency", lat, 9);

        // DC halfword and byte reads
        set_byte(32'h2001, 8'h34); set_byte(32'h2002, 8'h12);
        issue_dc(1'b0, 2'd1, 32'h2001, 32'h0);
        wait_done(0, 30, lat);
        chk("dc_half_latency", lat, 4);
        chk("dc_half_dat", bus.dc_dat, 32'h0000_1234);
        set_byte(32'h2100, 8'hFF);
        issue_dc(1'b0, 2'd0, 32'h2100, 32'h0);
        wait_done(0, 30, lat);
        chk("dc_byte_latency", lat, 3);
        chk("dc_byte_dat", bus.dc_dat, 32'h0000_00FF);

        // IO write stalled for 3 cycles
        w0 = wr_cnt;
        issue_dc(1'b1, 2'd3, 32'h30000, 32'h4433_2211);
        repeat (3) @(posedge clk_in);
        #1 io_dir = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 io_dir = 1'b0;
        wait_done(0, 30, lat);
        chk("io_stall_latency", lat, 8);
        chk("io_stall_strobes", wr_cnt - w0, 4);

        // IC abort in cycle T+3, fresh fetch at T+4
        for (int k = 0; k < 4; k++) begin
            set_byte(32'h400 + 32'(k), 8'hA0 + 8'(k));
            set_byte(32'h500 + 32'(k), 8'h50 + 8'(k));
        end
        issue_ic(32'h400);
        repeat (3) @(posedge clk_in);
        #1 bus.ic_abort = 1'b1;
        void'(exp_ic.pop_back());
        @(posedge clk_in);
        #1 bus.ic_abort = 1'b0;
        issue_ic(32'h500);
        wait_done(1, 30, lat);
        chk("post_abort_latency", lat, 6);
        chk("post_abort_dat", bus.ic_dat, 32'h5352_5150);

        // rdy_in low for 2 cycles mid-write
        issue_dc(1'b1, 2'd3, 32'h1234, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk_in);
        #1 rdy_dir = 1'b0;
        @(negedge clk_in);
        chk("freeze_mem_wr_0", bus.mem_wr, 0);
        @(negedge clk_in);
        chk("freeze_mem_wr_1", bus.mem_wr, 0);
        @(posedge clk_in);
        #1 rdy_dir = 1'b1;
        wait_done(0, 30, lat);
        chk("freeze_latency", lat, 7);

        // Reset mid-read
        issue_dc(1'b0, 2'd3, 32'h5000, 32'h0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        bus.dc_req_en = 1'b0;
        void'(exp_dc.pop_back());
        #1;
        chk("midreset_outputs", {bus.ic_done, bus.dc_done, bus.mem_wr, bus.mem_a, bus.mem_dout,
                                 bus.ic_dat, bus.dc_dat}, 0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        repeat (8) @(posedge clk_in);
        #1;
        issue_dc(1'b0, 2'd0, 32'h6000, 32'h0);
        wait_done(0, 30, lat);
        chk("post_reset_latency", lat, 3);

        // Randomized traffic with random rdy_in and io_buffer_full
        rand_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            case ($urandom_range(3))
                1: a[17:16] = 2'b11;
                2: a = 32'hFFFF_FFFC + 32'($urandom_range(3));
                3: a[17:2] = '1;
                default: ;
            endcase
            case ($urandom_range(2))
                0: len = 2'd0;
                1: len = 2'd1;
                default: len = 2'd3;
            endcase
            case ($urandom_range(2))
                0: begin issue_ic(a); wait_done(1, 400, lat); end
                1: begin issue_dc(1'b0, len, a, 32'h0); wait_done(0, 400, lat); end
                default: begin issue_dc(1'b1, len, a, $urandom); wait_done(0, 400, lat); end
            endcase
        end
        rand_en = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;

        chk("ic_queue_empty", exp_ic.size(), 0);
        chk("dc_queue_empty", exp_dc.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        mism = 0;
        for (int i = 0; i < 262144; i++)
            if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_image", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
